// File: rtl/reg_pipe_pkg.sv
// rtl/reg_pipe_pkg.sv - shared defaults and occupancy width helper for reg_pipe
package reg_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// rtl/reg_pipe_stage.sv - one pipeline stage: valid bit plus load-enabled data register
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int              WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RESET_DATA;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (adv) begin
                valid <= prev_valid;
            end
            // Data only moves with a real beat so idle stages keep their last value.
            if (adv && prev_valid && !flush) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - DEPTH-stage valid/ready register pipeline; REG_PIPE_OCC_EN adds the occ port
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter int               DEPTH      = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0] occ
`endif
);

    if (DEPTH < 1) begin : g_depth_check
        $error("reg_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] stage_data [DEPTH];

    // A stage may move when it is empty or the stage after it moves; this lets bubbles collapse.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = !stage_valid[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = !stage_valid[i] | adv[i+1];
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             pv;
        logic [WIDTH-1:0] pd;

        if (i == 0) begin : g_head
            assign pv = in_valid & in_ready;
            assign pd = in_data;
        end else begin : g_body
            assign pv = stage_valid[i-1];
            assign pd = stage_data[i-1];
        end

        reg_pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .adv        (adv[i]),
            .prev_valid (pv),
            .prev_data  (pd),
            .valid      (stage_valid[i]),
            .data       (stage_data[i])
        );
    end

`ifdef REG_PIPE_OCC_EN
    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = stage_valid[DEPTH-1] & out_ready;

    // Beats only enter at stage 0 and leave at the last stage, so +/-1 tracks popcount(valid).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb/tb_reg_pipe.sv - scoreboard testbench for reg_pipe; occ checks compiled under REG_PIPE_OCC_EN
module tb_reg_pipe;

    localparam int         WIDTH      = 8;
    localparam int         DEPTH      = 4;
    localparam logic [7:0] RESET_DATA = 8'h00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef REG_PIPE_OCC_EN
    logic [$clog2(DEPTH+1)-1:0] occ;
`endif

    reg_pipe #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RESET_DATA (RESET_DATA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef REG_PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] obs_q[$];
    int               in_cyc_q[$];
    int               out_cyc_q[$];

    // One clock cycle: record handshakes at the falling edge, return just after the rising edge.
    task automatic tick(output logic acc);
        acc = 1'b0;
        @(negedge clk);
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                in_cyc_q.push_back(cyc);
                acc = 1'b1;
            end
            if (out_valid && out_ready && !flush) begin
                obs_q.push_back(out_data);
                out_cyc_q.push_back(cyc);
            end
        end
        if (rst || flush) begin
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        in_cyc_q.delete();
        out_cyc_q.delete();
    endtask

    task automatic test_reset();
        logic acc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(acc);
        tick(acc);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== RESET_DATA) begin failures++; $display("FAIL reset_out_data got=%h exp=%h", out_data, RESET_DATA); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef REG_PIPE_OCC_EN
        checks++; if (occ !== 3'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occ); end
`endif
        clear_sb();
    endtask

    task automatic test_stream();
        logic acc;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] o;
        int n;
        clear_sb();
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            acc = 1'b0;
            for (int t = 0; t < 8 && !acc; t++) tick(acc);
            checks++; if (acc !== 1'b1) begin failures++; $display("FAIL stream_accept beat=%0d got=%b exp=1", k, acc); end
        end
        in_valid = 1'b0;
        for (int t = 0; t < 40 && (obs_q.size() < exp_q.size() || out_valid); t++) tick(acc);
        checks++; if (obs_q.size() != 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", obs_q.size()); end
        if (out_cyc_q.size() == 16 && in_cyc_q.size() == 16) begin
            checks++;
            if (out_cyc_q[0] - in_cyc_q[0] != DEPTH) begin
                failures++; $display("FAIL stream_latency got=%0d exp=%0d", out_cyc_q[0] - in_cyc_q[0], DEPTH);
            end
            checks++;
            if (out_cyc_q[15] - out_cyc_q[0] != 15) begin
                failures++; $display("FAIL stream_back_to_back span got=%0d exp=15", out_cyc_q[15] - out_cyc_q[0]);
            end
        end
        n = 0;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL stream_data idx=%0d got=%h exp=none", n, o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e || o !== 8'(n)) begin
                    failures++; $display("FAIL stream_data idx=%0d got=%h exp=%h", n, o, 8'(n));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] o;
        int idx;
        clear_sb();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h21 + idx);
            tick(acc);
            if (acc) idx++;
        end
        in_data = 8'(8'h21 + idx);
        #1;
        checks++; if (idx != 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", idx); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin
            failures++; $display("FAIL bp_head got=%b/%h exp=1/21", out_valid, out_data);
        end
`ifdef REG_PIPE_OCC_EN
        checks++; if (occ !== 3'd4) begin failures++; $display("FAIL bp_occ got=%0d exp=4", occ); end
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h21 + idx);
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        for (int t = 0; t < 40 && (obs_q.size() < exp_q.size() || out_valid); t++) tick(acc);
        checks++; if (obs_q.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", obs_q.size()); end
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (o !== e || o !== 8'(8'h21 + i)) begin
                failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, o, 8'(8'h21 + i));
            end
        end
    endtask

    task automatic test_bubble_collapse();
        logic acc;
        logic acc_a;
        logic acc_b;
        clear_sb();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5;
        tick(acc_a);
        in_valid = 1'b0;
        tick(acc);
        tick(acc);
        in_valid = 1'b1; in_data = 8'h5A;
        tick(acc_b);
        in_valid = 1'b0;
        for (int t = 0; t < 4; t++) tick(acc);
        #1;
        checks++; if (acc_a !== 1'b1 || acc_b !== 1'b1) begin
            failures++; $display("FAIL bubble_accept got=%b%b exp=11", acc_a, acc_b);
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            failures++; $display("FAIL bubble_head got=%b/%h exp=1/a5", out_valid, out_data);
        end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_in_ready got=%b exp=1", in_ready); end
`ifdef REG_PIPE_OCC_EN
        checks++; if (occ !== 3'd2) begin failures++; $display("FAIL bubble_occ got=%0d exp=2", occ); end
`endif
        out_ready = 1'b1;
        for (int t = 0; t < 20 && (obs_q.size() < exp_q.size() || out_valid); t++) tick(acc);
        checks++;
        if (obs_q.size() != 2 || out_cyc_q.size() != 2) begin
            failures++; $display("FAIL bubble_count got=%0d exp=2", obs_q.size());
        end else begin
            if (out_cyc_q[1] - out_cyc_q[0] != 1) begin
                failures++; $display("FAIL bubble_adjacent gap got=%0d exp=1", out_cyc_q[1] - out_cyc_q[0]);
            end
            checks++;
            if (obs_q[0] !== 8'hA5 || obs_q[1] !== 8'h5A || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
                failures++; $display("FAIL bubble_data got=%h,%h exp=a5,5a", obs_q[0], obs_q[1]);
            end
        end
        clear_sb();
    endtask

    task automatic test_flush();
        logic acc;
        int accepted;
        clear_sb();
        out_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + k);
            tick(acc);
            if (acc) accepted++;
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h34;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick(acc);
        if (acc) accepted++;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (accepted != 3) begin failures++; $display("FAIL flush_accepted got=%0d exp=3", accepted); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
`ifdef REG_PIPE_OCC_EN
        checks++; if (occ !== 3'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occ); end
`endif
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) tick(acc);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL flush_residue got=%0d exp=0", obs_q.size()); end
        clear_sb();
    endtask

    task automatic test_reset_mid();
        logic acc;
        int accepted;
        clear_sb();
        out_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h41 + k);
            tick(acc);
            if (acc) accepted++;
        end
        in_valid = 1'b0;
        #1;
        checks++; if (accepted != 4 || in_ready !== 1'b0 || out_data !== 8'h41) begin
            failures++; $display("FAIL rstmid_full got=%0d/%b/%h exp=4/0/41", accepted, in_ready, out_data);
        end
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== RESET_DATA) begin failures++; $display("FAIL rstmid_out_data got=%h exp=%h", out_data, RESET_DATA); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
`ifdef REG_PIPE_OCC_EN
        checks++; if (occ !== 3'd0) begin failures++; $display("FAIL rstmid_occ got=%0d exp=0", occ); end
`endif
        test_stream();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
